// File: rtl/pipe_rca_pkg.sv
// Shared helpers and reset constants for the pipelined ripple-carry adder.
package pipe_rca_pkg;

    localparam logic RST_VALID = 1'b0;
    localparam logic RST_BIT   = 1'b0;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal geometry: at least one stage, no empty slices, equal-width slices.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_fa_cell.sv
// One-bit full adder cell; the slices of pipe_rca_adder are chains of these.
module rca_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES registered slices.
// Optional macro PIPE_RCA_ADD_SUB_EN adds a 'sub' input that selects a - b.
module pipe_rca_adder
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_RCA_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $fatal(1, "pipe_rca_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] aEff;
    logic [WIDTH-1:0] bEff;
    logic             cinEff;
    logic             ovf_q;

    // Whole pipeline moves as one; a stalled output freezes every stage, bubbles included.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef PIPE_RCA_ADD_SUB_EN
    assign aEff   = a;
    assign bEff   = sub ? ~b : b;
    assign cinEff = sub ? 1'b1 : cin;
`else
    assign aEff   = a;
    assign bEff   = b;
    assign cinEff = cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SW;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]   opA;
        logic [REM-1:0]   opB;
        logic             ci;
        logic             validIn;
        logic [SW:0]      c;
        logic [SW-1:0]    s;
        logic [LO+SW-1:0] sum_d;
        logic [LO+SW-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        // Stage 0 works on the raw inputs; later stages on the bits held by their predecessor.
        if (k == 0) begin : g_src
            assign opA     = aEff;
            assign opB     = bEff;
            assign ci      = cinEff;
            assign validIn = in_valid;
            assign sum_d   = s;
        end else begin : g_src
            assign opA     = g_stage[k-1].g_hold.aHold_q;
            assign opB     = g_stage[k-1].g_hold.bHold_q;
            assign ci      = g_stage[k-1].carry_q;
            assign validIn = g_stage[k-1].valid_q;
            assign sum_d   = {s, g_stage[k-1].sum_q};
        end

        assign c[0] = ci;
        for (genvar i = 0; i < SW; i++) begin : g_bit
            rca_fa_cell u_fa (
                .a_i  (opA[i]),
                .b_i  (opB[i]),
                .ci_i (c[i]),
                .s_o  (s[i]),
                .co_o (c[i+1])
            );
        end

        if (k < STAGES - 1) begin : g_hold
            logic [REM-SW-1:0] aHold_q;
            logic [REM-SW-1:0] bHold_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    aHold_q <= {(REM-SW){RST_BIT}};
                    bHold_q <= {(REM-SW){RST_BIT}};
                end else if (advance) begin
                    aHold_q <= opA[REM-1:SW];
                    bHold_q <= opB[REM-1:SW];
                end
            end
        end

        // The output stage only loads real results so the ports hold their last value across bubbles.
        if (k == STAGES - 1) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= RST_VALID;
                    sum_q   <= {(LO+SW){RST_BIT}};
                    carry_q <= RST_BIT;
                    ovf_q   <= RST_BIT;
                end else if (advance) begin
                    valid_q <= validIn;
                    if (validIn) begin
                        sum_q   <= sum_d;
                        carry_q <= c[SW];
                        ovf_q   <= c[SW] ^ c[SW-1];
                    end
                end
            end
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= RST_VALID;
                    sum_q   <= {(LO+SW){RST_BIT}};
                    carry_q <= RST_BIT;
                end else if (advance) begin
                    valid_q <= validIn;
                    sum_q   <= sum_d;
                    carry_q <= c[SW];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = ovf_q;

endmodule
